// File: rtl/fifo_flagged.sv
// Single-clock FWFT FIFO with fill level, threshold flags and sticky
// overflow/underflow errors. Pointers carry an extra wrap bit.
module fifo_flagged #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 256,
    parameter int ALMOST_FULL  = DEPTH - 4,
    parameter int ALMOST_EMPTY = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         write_data,
    input  logic                     write_strobe,
    output logic [WIDTH-1:0]         read_data,
    input  logic                     read_strobe,
    output logic                     data_available,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clear_errors
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] AF_U = ALMOST_FULL;
    localparam logic [31:0] AE_U = ALMOST_EMPTY;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             read_accept, write_accept;
    logic [31:0]      level_ext;

    assign level          = wr_ptr_q - rd_ptr_q;
    assign level_ext      = {{(31 - AW){1'b0}}, level};
    assign data_available = wr_ptr_q != rd_ptr_q;
    assign full           = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
                          & (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign almost_full    = level_ext >= AF_U;
    assign almost_empty   = level_ext <= AE_U;
    assign read_data      = mem[rd_ptr_q[AW-1:0]];
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

    // A read frees the slot this edge, so a write into a full FIFO may proceed.
    assign read_accept  = read_strobe & data_available;
    assign write_accept = write_strobe & (~full | read_strobe);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear_errors) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (write_accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (read_accept)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (write_strobe && !write_accept) overflow_d  = 1'b1;
        if (read_strobe && !read_accept)   underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && write_accept) mem[wr_ptr_q[AW-1:0]] <= write_data;
    end
endmodule

// File: tb/tb_fifo_flagged.sv
// Scoreboard bench for fifo_flagged (DEPTH=8, ALMOST_FULL=6).
// Stimulus pushes accepted writes; a negedge monitor pops on each accepted read.
module tb_fifo_flagged;
    localparam int W = 8;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] write_data = '0;
    logic         write_strobe = 1'b0;
    logic [W-1:0] read_data;
    logic         read_strobe = 1'b0;
    logic         data_available, full, almost_full, almost_empty;
    logic [3:0]   level;
    logic         overflow, underflow;
    logic         clear_errors = 1'b0;

    int nchk = 0;
    int nfail = 0;
    logic [W-1:0] sb[$];
    int  mlevel = 0;
    bit  movf = 0;
    bit  mudf = 0;

    fifo_flagged #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL(6), .ALMOST_EMPTY(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .write_data(write_data), .write_strobe(write_strobe),
        .read_data(read_data), .read_strobe(read_strobe),
        .data_available(data_available), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow),
        .clear_errors(clear_errors)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs settle #1 after posedge, so negedge sees the upcoming accept.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && read_strobe === 1'b1 && data_available === 1'b1) begin
            if (sb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL rd_unexpected: got %0h expected none", read_data);
            end else begin
                chk("rd_data", int'(read_data), int'(sb.pop_front()));
            end
        end
    end

    task automatic cyc(input bit rn, input bit w, input logic [W-1:0] wd,
                       input bit r, input bit clr);
        bit aw, ar;
        reset_n      = rn;
        write_strobe = w;
        write_data   = wd;
        read_strobe  = r;
        clear_errors = clr;
        ar = r && mlevel != 0;
        aw = w && (mlevel != D || r);
        @(posedge clk);
        #1;
        if (!rn) begin
            sb.delete();
            mlevel = 0;
            movf = 0;
            mudf = 0;
        end else begin
            if (aw) sb.push_back(wd);
            mlevel += int'(aw) - int'(ar);
            if (clr) begin
                movf = 0;
                mudf = 0;
            end
            if (w && !aw) movf = 1;
            if (r && !ar) mudf = 1;
        end
        chk("level", int'(level), mlevel);
        chk("full", int'(full), int'(mlevel == D));
        chk("almost_full", int'(almost_full), int'(mlevel >= 6));
        chk("almost_empty", int'(almost_empty), int'(mlevel <= 4));
        chk("data_available", int'(data_available), int'(mlevel != 0));
        chk("overflow", int'(overflow), int'(movf));
        chk("underflow", int'(underflow), int'(mudf));
    endtask

    task automatic wr(input logic [W-1:0] d);
        cyc(1, 1, d, 0, 0);
    endtask

    task automatic rd();
        cyc(1, 0, 8'h00, 1, 0);
    endtask

    initial begin
        // 1: reset with strobes active
        cyc(0, 1, 8'hEE, 1, 0);
        cyc(0, 1, 8'hEE, 1, 0);
        // 2: fill, overflow, drain
        for (int i = 0; i < 8; i++) wr(8'(8'h10 + i));
        wr(8'hAA);
        for (int i = 0; i < 8; i++) rd();
        cyc(1, 0, 8'h00, 0, 1);
        // 3: empty read then clear
        rd();
        cyc(1, 0, 8'h00, 0, 1);
        // 4: full with simultaneous read/write
        for (int i = 0; i < 8; i++) wr(8'(8'h60 + i));
        cyc(1, 1, 8'h55, 1, 0);
        for (int i = 0; i < 8; i++) rd();
        // 5: empty with simultaneous read/write
        cyc(1, 1, 8'h33, 1, 0);
        chk("fwft_33", int'(read_data), 32'h33);
        rd();
        // clear and error in same cycle: error wins
        cyc(1, 0, 8'h00, 1, 1);
        cyc(1, 0, 8'h00, 0, 1);
        // 6: random interleave across several wraps
        for (int i = 0; i < 3 * D * 2; i++)
            cyc(1, bit'($urandom_range(0, 1)), 8'($urandom),
                bit'($urandom_range(0, 1)), 0);
        while (mlevel > 0) rd();
        cyc(1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) wr(8'(8'hC0 + i));
        cyc(0, 1, 8'hEE, 0, 0);
        wr(8'h42);
        chk("post_reset_head", int'(read_data), 32'h42);
        rd();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
